// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the RAM preloader: controller state
//                encodings, write-granularity (Mode/MemType) encodings and a
//                helper that maps a Mode to its group size in bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Controller states
    localparam int unsigned     c_st_w        = 3;
    localparam logic [c_st_w-1:0] c_st_idle     = 3'd0;
    localparam logic [c_st_w-1:0] c_st_collect  = 3'd1;
    localparam logic [c_st_w-1:0] c_st_write    = 3'd2;
    localparam logic [c_st_w-1:0] c_st_wait_mfc = 3'd3;
    localparam logic [c_st_w-1:0] c_st_done     = 3'd4;

    // Write granularity; 2'b11 is accepted and behaves as a word access
    localparam logic [1:0] c_mode_byte = 2'b00;
    localparam logic [1:0] c_mode_half = 2'b01;
    localparam logic [1:0] c_mode_word = 2'b10;

    // Number of bytes that make up one RAM write for the given mode
    function automatic logic [2:0] size_from_mode(input logic [1:0] mode);
        case (mode)
            c_mode_byte: size_from_mode = 3'd1;
            c_mode_half: size_from_mode = 3'd2;
            default:     size_from_mode = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles accepted stream bytes MSB-first into one RAM write
//                group, counts the bytes in the group and left-justifies a
//                partial group with zero-filled trailing bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_mode,
    output logic        o_group_done,
    output logic        o_empty,
    output logic [31:0] o_data
);

    logic [31:0] r_shift;
    logic [2:0]  r_count;
    logic [2:0]  w_size;
    logic [2:0]  w_pad;
    logic [5:0]  w_shamt;

    // Shift accepted bytes in from the right; the oldest byte ends up highest
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_accept) begin
            r_shift <= {r_shift[23:0], i_byte};
            r_count <= r_count + 3'd1;
        end
    end

    // Left-justify the collected bytes so missing trailing bytes read as zero
    always_comb begin
        w_size       = size_from_mode(i_mode);
        w_pad        = 3'd4 - r_count;
        w_shamt      = {w_pad, 3'b000};
        o_data       = r_shift << w_shamt;
        o_group_done = i_accept && ((r_count + 3'd1) == w_size);
        o_empty      = (r_count == 3'd0);
    end

endmodule
`default_nettype wire

// File: rtl/mem_preloader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_preloader
//  Description : Loads a byte stream into a RAM through a MAR/MDR-style
//                request/complete handshake, in byte, halfword or word
//                groups, with address wrap and a per-session byte limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_preloader
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int WORD_W    = 32,
    parameter int MAX_BYTES = 512
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [1:0]        Mode,
    input  logic [7:0]        InData,
    input  logic              InValid,
    input  logic              InLast,
    output logic              InReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    output logic [1:0]        MemType,
    output logic              MemRW,
    output logic              MemMov,
    input  logic              MemMfc,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   ByteCount
);

    generate
        if (WORD_W != 32) begin : g_word_w_check
            $error("mem_preloader: WORD_W must be 32 (4-byte data port)");
        end
    endgenerate

    localparam logic [ADDR_W:0] c_max_bytes = MAX_BYTES[ADDR_W:0];
    localparam logic [ADDR_W:0] c_one       = 1;

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_mode;
    logic [ADDR_W:0]   r_count;
    logic              r_last;
    logic              r_mfc_seen;

    logic              w_start;
    logic              w_accept;
    logic              w_at_max;
    logic              w_hits_max;
    logic              w_mfc_exit;
    logic              w_group_done;
    logic              w_pack_empty;
    logic [31:0]       w_pack_data;
    logic [2:0]        w_size;
    logic [2:0]        w_start_size;
    logic [ADDR_W-1:0] w_size_addr;
    logic [ADDR_W-1:0] w_align_mask;

    // Handshake and session qualifiers shared by the FSM and the datapath
    always_comb begin
        w_start      = (r_state == c_st_idle) && Start;
        w_accept     = InValid && InReady;
        w_at_max     = (r_count >= c_max_bytes);
        w_hits_max   = ((r_count + c_one) == c_max_bytes);
        w_mfc_exit   = (r_state == c_st_wait_mfc) && (MemMfc || r_mfc_seen);
        w_size       = size_from_mode(r_mode);
        w_start_size = size_from_mode(Mode);
        w_size_addr  = {{(ADDR_W-3){1'b0}}, w_size};
        w_align_mask = ~{{(ADDR_W-3){1'b0}}, w_start_size - 3'd1};
    end

    byte_packer u_packer (
        .clk          (Clk),
        .rst          (Clr),
        .i_clear      (w_start || w_mfc_exit),
        .i_accept     (w_accept),
        .i_byte       (InData),
        .i_mode       (r_mode),
        .o_group_done (w_group_done),
        .o_empty      (w_pack_empty),
        .o_data       (w_pack_data)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state outputs
    always_comb begin
        w_next_state = r_state;
        InReady      = 1'b0;
        MemMov       = 1'b0;
        Busy         = 1'b1;
        Done         = 1'b0;
        case (r_state)
            c_st_idle: begin
                Busy = 1'b0;
                if (Start) w_next_state = c_st_collect;
            end
            c_st_collect: begin
                InReady = !w_at_max;
                if (w_at_max) begin
                    // Limit already reached: flush whatever is pending
                    w_next_state = w_pack_empty ? c_st_done : c_st_write;
                end else if (w_accept && (w_group_done || InLast || w_hits_max)) begin
                    w_next_state = c_st_write;
                end
            end
            c_st_write: begin
                MemMov       = 1'b1;
                w_next_state = c_st_wait_mfc;
            end
            c_st_wait_mfc: begin
                MemMov = 1'b1;
                if (w_mfc_exit) begin
                    w_next_state = (r_last || w_at_max) ? c_st_done : c_st_collect;
                end
            end
            c_st_done: begin
                Done         = 1'b1;
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
        MemRW     = !MemMov;
        MemAddr   = r_addr;
        MemData   = w_pack_data;
        MemType   = r_mode;
        ByteCount = r_count;
    end

    // Session registers: address pointer, latched mode, byte count, last flag
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_addr     <= '0;
            r_mode     <= '0;
            r_count    <= '0;
            r_last     <= 1'b0;
            r_mfc_seen <= 1'b0;
        end else begin
            // A completion seen while the request first rises is remembered
            r_mfc_seen <= (r_state == c_st_write) && MemMfc;
            if (w_start) begin
                r_addr  <= BaseAddr & w_align_mask;
                r_mode  <= Mode;
                r_count <= '0;
                r_last  <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_count <= r_count + c_one;
                    if (InLast) r_last <= 1'b1;
                end
                if (w_mfc_exit) begin
                    r_addr <= r_addr + w_size_addr;
                end
            end
        end
    end

endmodule
`default_nettype wire
